brew_sequencer: RTL

- Initiator side of the `temporizador` interface: drives `value` and `start_timer`, consumes `texpired`.
- Runs one coffee recipe as an ordered series of timed dispensing stages: water, coffee, milk, chocolate.
- Opens the valve for each active stage and holds it open until the timer expires.
- Sits between front-panel button/recipe logic and the timer/valve drivers.

---
 rtl/brew_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/brew_sequencer.sv
// Coffee brew sequencer: walks a recipe through timed valve stages,
// arming an external timer per stage and guarding it with a watchdog.
module brew_sequencer #(
  parameter int VALUE_W  = 4,
  parameter int WD_W     = 32,
  parameter int WD_LIMIT = 500_000_000
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         recipe,
  input  logic               cancel,
  input  logic               texpired,
  output logic [VALUE_W-1:0] value,
  output logic               start_timer,
  output logic               valve_water,
  output logic               valve_coffee,
  output logic               valve_milk,
  output logic               valve_choc,
  output logic [1:0]         stage,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ARM,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [1:0] recipe_q, recipe_d;
  logic [WD_W-1:0] wd_q, wd_d, wd_inc;
  logic guard_q, guard_d;
  logic abort_q, abort_d;
  logic [VALUE_W-1:0] code;
  logic open;

  // Duration code per {recipe, stage}; zero means the stage is skipped.
  always_comb begin
    code = '0;
    case ({recipe_q, stage_q})
      4'b00_01: code = VALUE_W'(3);
      4'b01_00: code = VALUE_W'(5);
      4'b01_01: code = VALUE_W'(3);
      4'b10_01: code = VALUE_W'(3);
      4'b10_10: code = VALUE_W'(6);
      4'b11_01: code = VALUE_W'(3);
      4'b11_10: code = VALUE_W'(4);
      4'b11_11: code = VALUE_W'(2);
      default:  code = '0;
    endcase
  end

  assign wd_inc = (&wd_q) ? wd_q : wd_q + WD_W'(1);

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    recipe_d = recipe_q;
    wd_d     = wd_q;
    guard_d  = 1'b0;
    abort_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          recipe_d = recipe;
          stage_d  = 2'd0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (code != '0) begin
          state_d = S_ARM;
        end else if (stage_q != 2'd3) begin
          stage_d = stage_q + 2'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ARM: begin
        wd_d    = '0;
        guard_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle may still see the previous stage's expiry.
        if (texpired && !guard_q) begin
          if (stage_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = S_SELECT;
          end
        end else if (!texpired) begin
          wd_d = wd_inc;
          if (wd_inc >= WD_W'(WD_LIMIT)) begin
            state_d = S_FAULT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (cancel && state_q != S_IDLE && state_q != S_FAULT) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end
    if (state_d == S_IDLE || state_d == S_FAULT) begin
      stage_d = 2'd0;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stage_q  <= 2'd0;
      recipe_q <= 2'd0;
      wd_q     <= '0;
      guard_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      recipe_q <= recipe_d;
      wd_q     <= wd_d;
      guard_q  <= guard_d;
      abort_q  <= abort_d;
    end
  end

  assign open         = (state_q == S_ARM) || (state_q == S_WAIT);
  assign value        = open ? code : '0;
  assign start_timer  = (state_q == S_ARM);
  assign valve_water  = open && (stage_q == 2'd0);
  assign valve_coffee = open && (stage_q == 2'd1);
  assign valve_milk   = open && (stage_q == 2'd2);
  assign valve_choc   = open && (stage_q == 2'd3);
  assign stage        = stage_q;
  assign busy         = (state_q == S_SELECT) || open;
  assign done         = (state_q == S_DONE);
  assign aborted      = abort_q;
  assign fault        = (state_q == S_FAULT);

endmodule
